duty_cycle_monitor: RTL and testbench

Half-cycle-resolution period and duty-cycle checker for a divided clock generated from `clockin`, such as the output of the fractional (divide-by-N.5) dividers. It samples `divclk` on both edges of `clockin` and reports period and high time in half-cycles for every `divclk` period. It flags periods outside tolerance and asserts a lock indication after a run of good periods. It sits directly downstream of the divider, as its on-chip checker.

---
 rtl/duty_cycle_monitor.sv | 171 +++++++++++++++++
 tb/tb_duty_cycle_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/duty_cycle_monitor.sv
// Half-cycle-resolution period / duty-cycle checker for a divided clock derived from clockin.
// divclk is sampled on both clockin edges; each posedge processes the ordered pair (a = negedge sample, b = posedge sample).
module duty_cycle_monitor #(
    parameter int CW         = 8,
    parameter int EXP_PERIOD = 9,
    parameter int TOL        = 0,
    parameter int LOCK_N     = 4
) (
    input  logic          clockin,
    input  logic          reset,
    input  logic          divclk,
    input  logic          clr_err,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high,
    output logic          valid,
    output logic          err,
    output logic          err_flag,
    output logic          locked,
    output logic          stuck
);

    localparam logic [CW-1:0] SAT_V  = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_V  = CW'(1);
    localparam logic [CW-1:0] TWO_V  = CW'(2);
    localparam logic [CW:0]   EXP_V  = (CW+1)'(EXP_PERIOD);
    localparam logic [CW:0]   TOL_V  = (CW+1)'(TOL);
    localparam int            LW     = $clog2(LOCK_N + 1);
    localparam logic [LW-1:0] LOCK_V = LW'(LOCK_N);

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    state_t        state_r;
    logic          sn_r;
    logic          z_r;
    logic [CW-1:0] acc_r;
    logic [CW-1:0] hacc_r;
    logic [CW-1:0] period_r;
    logic [CW-1:0] high_r;
    logic          valid_r;
    logic          err_r;
    logic          err_flag_r;
    logic          locked_r;
    logic          stuck_r;
    logic [LW-1:0] lock_cnt_r;

    logic          rise_a_s;
    logic          rise_b_s;
    logic [1:0]    ab_sum_s;
    logic [CW-1:0] acc_inc_s;
    logic [CW-1:0] hacc_inc_s;
    logic          sat_hit_s;
    logic [CW-1:0] meas_period_s;
    logic [CW-1:0] meas_high_s;
    logic [CW:0]   dev_s;
    logic          bad_s;
    logic [LW-1:0] lock_next_s;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] x, input logic [1:0] y);
        logic [CW:0] s;
        s = {1'b0, x} + {{(CW-1){1'b0}}, y};
        return s[CW] ? SAT_V : s[CW-1:0];
    endfunction

    // Capture the first sample of each pair on the falling edge.
    always_ff @(negedge clockin or negedge reset) begin
        if (!reset) begin
            sn_r <= 1'b0;
        end else begin
            sn_r <= divclk;
        end
    end

    // Rise detection, accumulator updates, period deviation and next lock count.
    always_comb begin
        rise_a_s   = ~z_r & sn_r;
        rise_b_s   = ~sn_r & divclk;
        ab_sum_s   = {1'b0, sn_r} + {1'b0, divclk};
        acc_inc_s  = sat_add(acc_r, 2'd2);
        hacc_inc_s = sat_add(hacc_r, ab_sum_s);
        // Saturation is an event: only the step that first reaches the ceiling counts.
        sat_hit_s  = ~(rise_a_s | rise_b_s) & (acc_r != SAT_V) & (acc_inc_s == SAT_V);
        if (rise_a_s) begin
            meas_period_s = acc_r;
            meas_high_s   = hacc_r;
        end else begin
            meas_period_s = sat_add(acc_r, 2'd1);
            meas_high_s   = sat_add(hacc_r, {1'b0, sn_r});
        end
        if ({1'b0, meas_period_s} >= EXP_V) begin
            dev_s = {1'b0, meas_period_s} - EXP_V;
        end else begin
            dev_s = EXP_V - {1'b0, meas_period_s};
        end
        bad_s = (dev_s > TOL_V);
        if (lock_cnt_r == LOCK_V) begin
            lock_next_s = lock_cnt_r;
        end else begin
            lock_next_s = lock_cnt_r + LW'(1);
        end
    end

    // Measurement state machine with registered reports, lock tracking and sticky flags.
    always_ff @(posedge clockin or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            z_r        <= 1'b0;
            acc_r      <= '0;
            hacc_r     <= '0;
            period_r   <= '0;
            high_r     <= '0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            err_flag_r <= 1'b0;
            locked_r   <= 1'b0;
            stuck_r    <= 1'b0;
            lock_cnt_r <= '0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            z_r     <= divclk;
            // Clear first so that a coincident set below takes priority.
            if (clr_err) begin
                err_flag_r <= 1'b0;
                stuck_r    <= 1'b0;
            end
            if (rise_a_s || rise_b_s) begin
                acc_r   <= rise_a_s ? TWO_V : ONE_V;
                hacc_r  <= rise_a_s ? {{(CW-2){1'b0}}, ab_sum_s} : ONE_V;
                state_r <= MEASURE;
                case (state_r)
                    MEASURE: begin
                        period_r <= meas_period_s;
                        high_r   <= meas_high_s;
                        valid_r  <= 1'b1;
                        if (bad_s) begin
                            err_r      <= 1'b1;
                            err_flag_r <= 1'b1;
                            lock_cnt_r <= '0;
                            locked_r   <= 1'b0;
                        end else begin
                            lock_cnt_r <= lock_next_s;
                            locked_r   <= locked_r | (lock_next_s == LOCK_V);
                        end
                    end
                    default: begin
                        valid_r <= 1'b0;
                    end
                endcase
            end else if (sat_hit_s) begin
                acc_r      <= SAT_V;
                hacc_r     <= hacc_inc_s;
                stuck_r    <= 1'b1;
                locked_r   <= 1'b0;
                lock_cnt_r <= '0;
                state_r    <= IDLE;
            end else begin
                acc_r  <= acc_inc_s;
                hacc_r <= hacc_inc_s;
            end
        end
    end

    assign period   = period_r;
    assign high     = high_r;
    assign valid    = valid_r;
    assign err      = err_r;
    assign err_flag = err_flag_r;
    assign locked   = locked_r;
    assign stuck    = stuck_r;

endmodule

// File: tb/tb_duty_cycle_monitor.sv
// Directed bench for duty_cycle_monitor: divclk is streamed as half-cycle samples from a queue.
module tb_duty_cycle_monitor;

    logic clockin = 1'b0;
    logic reset   = 1'b0;
    logic divclk  = 1'b0;
    logic clr_err = 1'b0;

    logic [7:0] period0, high0, period8, high8, period2, high2;
    logic v0, e0, f0, l0, s0;
    logic v8, e8, f8, l8, s8;
    logic v2, e2, f2, l2, s2;

    duty_cycle_monitor u_dut (
        .clockin(clockin), .reset(reset), .divclk(divclk), .clr_err(clr_err),
        .period(period0), .high(high0), .valid(v0), .err(e0),
        .err_flag(f0), .locked(l0), .stuck(s0)
    );

    duty_cycle_monitor #(.EXP_PERIOD(8)) u_dut8 (
        .clockin(clockin), .reset(reset), .divclk(divclk), .clr_err(clr_err),
        .period(period8), .high(high8), .valid(v8), .err(e8),
        .err_flag(f8), .locked(l8), .stuck(s8)
    );

    duty_cycle_monitor #(.EXP_PERIOD(2)) u_dut2 (
        .clockin(clockin), .reset(reset), .divclk(divclk), .clr_err(clr_err),
        .period(period2), .high(high2), .valid(v2), .err(e2),
        .err_flag(f2), .locked(l2), .stuck(s2)
    );

    always #5 clockin = ~clockin;

    int sel = 0;
    logic [7:0] m_period, m_high;
    logic m_valid, m_err, m_flag, m_locked, m_stuck;
    assign m_period = (sel == 1) ? period8 : (sel == 2) ? period2 : period0;
    assign m_high   = (sel == 1) ? high8   : (sel == 2) ? high2   : high0;
    assign m_valid  = (sel == 1) ? v8 : (sel == 2) ? v2 : v0;
    assign m_err    = (sel == 1) ? e8 : (sel == 2) ? e2 : e0;
    assign m_flag   = (sel == 1) ? f8 : (sel == 2) ? f2 : f0;
    assign m_locked = (sel == 1) ? l8 : (sel == 2) ? l2 : l0;
    assign m_stuck  = (sel == 1) ? s8 : (sel == 2) ? s2 : s0;

    int checks = 0;
    int errors = 0;

    bit q[$];
    bit idle_val = 1'b0;

    int nv, err_cnt, stuck_cyc, max_run, run;
    int         vc[64];
    logic [7:0] vp[64];
    logic [7:0] vh[64];
    logic       ve[64];
    logic       vl[64];
    logic       vf[64];

    task automatic push_period(input int p, input int h);
        for (int i = 0; i < p; i++) q.push_back(i < h);
    endtask

    function automatic bit pop_s();
        if (q.size() > 0) return q.pop_front();
        return idle_val;
    endfunction

    task automatic clear_rec();
        nv = 0; err_cnt = 0; stuck_cyc = -1; max_run = 0; run = 0;
    endtask

    // One clockin cycle per iteration: first sample taken at negedge, second at posedge.
    task automatic drain(input int n);
        for (int c = 0; c < n; c++) begin
            divclk = pop_s();
            @(negedge clockin); #1;
            divclk = pop_s();
            @(posedge clockin); #1;
            if (m_valid) begin
                if (nv < 64) begin
                    vc[nv] = c; vp[nv] = m_period; vh[nv] = m_high;
                    ve[nv] = m_err; vl[nv] = m_locked; vf[nv] = m_flag;
                end
                nv++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (m_err) err_cnt++;
            if (m_stuck && stuck_cyc < 0) stuck_cyc = c;
        end
    endtask

    task automatic do_reset();
        q.delete(); idle_val = 1'b0; divclk = 1'b0; clr_err = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clockin);
        #1 reset = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clockin); #1;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        @(posedge clockin); #1;
        checks++; if ({period0, high0, v0, e0, f0, l0, s0} !== 21'd0) begin errors++; $display("FAIL rst_por_dut got %0h exp 0", {period0, high0, v0, e0, f0, l0, s0}); end
        checks++; if ({period8, high8, v8, e8, f8, l8, s8} !== 21'd0) begin errors++; $display("FAIL rst_por_dut8 got %0h exp 0", {period8, high8, v8, e8, f8, l8, s8}); end
        checks++; if ({period2, high2, v2, e2, f2, l2, s2} !== 21'd0) begin errors++; $display("FAIL rst_por_dut2 got %0h exp 0", {period2, high2, v2, e2, f2, l2, s2}); end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) push_period(9, 4);
        clear_rec();
        drain(30);
        checks++; if (l0 !== 1'b1) begin errors++; $display("FAIL rst_prelock got %0b exp 1", l0); end
        checks++; if (period0 !== 8'd9) begin errors++; $display("FAIL rst_preperiod got %0d exp 9", period0); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({period0, high0, v0, e0, f0, l0, s0} !== 21'd0) begin errors++; $display("FAIL rst_async got %0h exp 0", {period0, high0, v0, e0, f0, l0, s0}); end
        @(posedge clockin); #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) push_period(9, 4);
        clear_rec();
        drain(14);
        checks++; if (nv !== 2) begin errors++; $display("FAIL rst_nvalid got %0d exp 2", nv); end
        checks++; if (vc[0] !== 4) begin errors++; $display("FAIL rst_first_valid_cycle got %0d exp 4", vc[0]); end
        checks++; if (vp[0] !== 8'd9 || vh[0] !== 8'd4) begin errors++; $display("FAIL rst_first_meas got %0d/%0d exp 9/4", vp[0], vh[0]); end
    endtask

    task automatic test_nominal_lock();
        do_reset(); sel = 0;
        for (int i = 0; i < 8; i++) push_period(9, 4);
        clear_rec();
        drain(40);
        checks++; if (nv !== 7) begin errors++; $display("FAIL nom_nvalid got %0d exp 7", nv); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (vp[i] !== 8'd9 || vh[i] !== 8'd4) begin errors++; $display("FAIL nom_meas[%0d] got %0d/%0d exp 9/4", i, vp[i], vh[i]); end
        end
        checks++; if (vc[0] !== 4 || vc[1] !== 9 || vc[2] !== 13) begin errors++; $display("FAIL nom_cycles got %0d,%0d,%0d exp 4,9,13", vc[0], vc[1], vc[2]); end
        checks++; if (vl[2] !== 1'b0 || vl[3] !== 1'b1) begin errors++; $display("FAIL nom_lock got v3=%0b v4=%0b exp 0,1", vl[2], vl[3]); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL nom_err got %0d exp 0", err_cnt); end
        checks++; if (max_run !== 1) begin errors++; $display("FAIL nom_pulse got %0d exp 1", max_run); end
    endtask

    task automatic test_out_of_tol();
        do_reset(); sel = 0;
        for (int i = 0; i < 5; i++) push_period(9, 4);
        push_period(10, 4);
        for (int i = 0; i < 6; i++) push_period(9, 4);
        clear_rec();
        drain(58);
        checks++; if (nv !== 11) begin errors++; $display("FAIL tol_nvalid got %0d exp 11", nv); end
        checks++; if (vp[5] !== 8'd10 || vh[5] !== 8'd4) begin errors++; $display("FAIL tol_meas got %0d/%0d exp 10/4", vp[5], vh[5]); end
        checks++; if (ve[5] !== 1'b1 || vf[5] !== 1'b1) begin errors++; $display("FAIL tol_err got %0b/%0b exp 1/1", ve[5], vf[5]); end
        checks++; if (vl[4] !== 1'b1 || vl[5] !== 1'b0) begin errors++; $display("FAIL tol_unlock got %0b,%0b exp 1,0", vl[4], vl[5]); end
        checks++; if (vl[8] !== 1'b0 || vl[9] !== 1'b1) begin errors++; $display("FAIL tol_relock got %0b,%0b exp 0,1", vl[8], vl[9]); end
        checks++; if (vp[6] !== 8'd9 || ve[6] !== 1'b0) begin errors++; $display("FAIL tol_after got %0d/%0b exp 9/0", vp[6], ve[6]); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL tol_err_count got %0d exp 1", err_cnt); end
        checks++; if (f0 !== 1'b1) begin errors++; $display("FAIL tol_sticky got %0b exp 1", f0); end
        pulse_clr();
        checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL tol_clr got %0b exp 0", f0); end
    endtask

    task automatic test_even_division();
        do_reset(); sel = 1;
        for (int i = 0; i < 6; i++) push_period(8, 4);
        clear_rec();
        drain(26);
        checks++; if (nv !== 5) begin errors++; $display("FAIL even_nvalid got %0d exp 5", nv); end
        checks++; if (vc[0] !== 4) begin errors++; $display("FAIL even_first got %0d exp 4", vc[0]); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (vp[i] !== 8'd8 || vh[i] !== 8'd4) begin errors++; $display("FAIL even_meas[%0d] got %0d/%0d exp 8/4", i, vp[i], vh[i]); end
        end
        for (int i = 1; i < 5; i++) begin
            checks++; if (vc[i] - vc[i-1] !== 4) begin errors++; $display("FAIL even_spacing[%0d] got %0d exp 4", i, vc[i] - vc[i-1]); end
        end
        checks++; if (vl[3] !== 1'b1 || err_cnt !== 0) begin errors++; $display("FAIL even_lock got %0b err %0d exp 1 err 0", vl[3], err_cnt); end
    endtask

    task automatic test_stuck_high();
        do_reset(); sel = 0;
        for (int i = 0; i < 5; i++) push_period(9, 4);
        idle_val = 1'b1;
        clear_rec();
        drain(160);
        checks++; if (nv !== 5) begin errors++; $display("FAIL stuck_nvalid got %0d exp 5", nv); end
        checks++; if (vl[4] !== 1'b1 || vc[4] !== 22) begin errors++; $display("FAIL stuck_prelock got %0b@%0d exp 1@22", vl[4], vc[4]); end
        checks++; if (stuck_cyc !== 149) begin errors++; $display("FAIL stuck_cycle got %0d exp 149", stuck_cyc); end
        checks++; if (s0 !== 1'b1 || l0 !== 1'b0) begin errors++; $display("FAIL stuck_flags got stuck=%0b locked=%0b exp 1/0", s0, l0); end
        checks++; if (period0 !== 8'd9) begin errors++; $display("FAIL stuck_hold got %0d exp 9", period0); end
        idle_val = 1'b0;
        for (int i = 0; i < 4; i++) push_period(9, 4);
        clear_rec();
        drain(22);
        checks++; if (nv !== 2) begin errors++; $display("FAIL stuck_resume_n got %0d exp 2", nv); end
        checks++; if (vc[0] !== 9) begin errors++; $display("FAIL stuck_resume_cycle got %0d exp 9", vc[0]); end
        checks++; if (vp[0] !== 8'd9 || vh[0] !== 8'd4 || vp[1] !== 8'd9) begin errors++; $display("FAIL stuck_resume_meas got %0d/%0d,%0d exp 9/4,9", vp[0], vh[0], vp[1]); end
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL stuck_sticky got %0b exp 1", s0); end
        pulse_clr();
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL stuck_clr got %0b exp 0", s0); end
    endtask

    task automatic test_min_period();
        do_reset(); sel = 2;
        for (int i = 0; i < 10; i++) push_period(2, 1);
        clear_rec();
        drain(14);
        checks++; if (nv !== 9) begin errors++; $display("FAIL min_nvalid got %0d exp 9", nv); end
        checks++; if (vc[0] !== 1) begin errors++; $display("FAIL min_first got %0d exp 1", vc[0]); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (vp[i] !== 8'd2 || vh[i] !== 8'd1) begin errors++; $display("FAIL min_meas[%0d] got %0d/%0d exp 2/1", i, vp[i], vh[i]); end
        end
        checks++; if (max_run !== 9) begin errors++; $display("FAIL min_run got %0d exp 9", max_run); end
        checks++; if (vl[3] !== 1'b1 || err_cnt !== 0) begin errors++; $display("FAIL min_lock got %0b err %0d exp 1 err 0", vl[3], err_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_out_of_tol();
        test_even_division();
        test_stuck_high();
        test_min_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
